// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings for the MIPS16 pipeline hazard controller
package hazard_ctrl_pkg;
  localparam int REG_ADDR_W = 4;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [2:0] reg_op_t;
  typedef logic [1:0] wb_data_op_t;
  typedef logic [1:0] ram_op_t;
  localparam reg_op_t REG_OP_NONE = 3'd0;
  localparam reg_op_t REG_OP_REG = 3'd1;
  localparam reg_op_t REG_OP_SP = 3'd2;
  localparam reg_op_t REG_OP_T = 3'd3;
  localparam reg_op_t REG_OP_IH = 3'd4;
  localparam wb_data_op_t WB_DATA_OP_ALU = 2'd0;
  localparam wb_data_op_t WB_DATA_OP_MEM = 2'd1;
  localparam wb_data_op_t WB_DATA_OP_PC = 2'd2;
  localparam ram_op_t RAM_OP_NOP = 2'd0;
  localparam ram_op_t RAM_OP_LOAD = 2'd1;
  localparam ram_op_t RAM_OP_STORE = 2'd2;
  typedef enum logic [1:0] {S_RUN, S_MEM, S_INT} state_t;
  localparam logic STALL = 1'b1;
  localparam logic FLUSH = 1'b1;
  localparam logic RAM_SEL_FETCH = 1'b0;
  localparam logic RAM_SEL_DATA = 1'b1;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline status in, stall/flush/select controls out
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;
  reg_addr_t id_reg1_addr, id_reg2_addr, ieo_wb_addr;
  logic id_reg1_used, id_reg2_used, id_sp_used, id_t_used, id_ih_used;
  reg_op_t ieo_reg_op;
  wb_data_op_t ieo_wb_data_op;
  ram_op_t emo_ram_op;
  logic emo_ram_is_inst, ex_branch_taken, int_req, ih_int_enable;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, mem_wb_flush, inst_ram_sel, int_entry;
  modport master (
    output id_reg1_addr, id_reg2_addr, id_reg1_used, id_reg2_used, id_sp_used, id_t_used, id_ih_used,
    output ieo_wb_addr, ieo_reg_op, ieo_wb_data_op, emo_ram_op, emo_ram_is_inst,
    output ex_branch_taken, int_req, ih_int_enable,
    input pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    input if_id_flush, id_ex_flush, mem_wb_flush, inst_ram_sel, int_entry
  );
  modport slave (
    input id_reg1_addr, id_reg2_addr, id_reg1_used, id_reg2_used, id_sp_used, id_t_used, id_ih_used,
    input ieo_wb_addr, ieo_reg_op, ieo_wb_data_op, emo_ram_op, emo_ram_is_inst,
    input ex_branch_taken, int_req, ih_int_enable,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    output if_id_flush, id_ex_flush, mem_wb_flush, inst_ram_sel, int_entry
  );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: flags an ID instruction reading the destination of a load in EX
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  reg_addr_t   id_reg1_addr_i,
  input  reg_addr_t   id_reg2_addr_i,
  input  logic        id_reg1_used_i,
  input  logic        id_reg2_used_i,
  input  logic        id_sp_used_i,
  input  logic        id_t_used_i,
  input  logic        id_ih_used_i,
  input  reg_addr_t   ieo_wb_addr_i,
  input  reg_op_t     ieo_reg_op_i,
  input  wb_data_op_t ieo_wb_data_op_i,
  output logic        load_use_o
);
  logic gpr_hit;
  always_comb begin
    gpr_hit = (id_reg1_used_i && id_reg1_addr_i == ieo_wb_addr_i)
           || (id_reg2_used_i && id_reg2_addr_i == ieo_wb_addr_i);
    load_use_o = ieo_wb_data_op_i == WB_DATA_OP_MEM && (
                   (ieo_reg_op_i == REG_OP_REG && gpr_hit)
                || (ieo_reg_op_i == REG_OP_SP && id_sp_used_i)
                || (ieo_reg_op_i == REG_OP_T && id_t_used_i)
                || (ieo_reg_op_i == REG_OP_IH && id_ih_used_i));
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush sequencing for load-use, instruction-RAM data
// access, taken branches and interrupt entry; also selects the shared RAM port.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RAM_WAIT = 1
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave hz
);
  localparam bit LONG = RAM_WAIT > 1;
  localparam logic [2:0] CNT_INIT = 3'(RAM_WAIT - 1);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic blk_q, blk_d;
  logic load_use, conflict, run, mem, in_int, last, rc, br, br_run, lu, accept, hold;
  hazard_detect u_detect (
    .id_reg1_addr_i  (hz.id_reg1_addr),
    .id_reg2_addr_i  (hz.id_reg2_addr),
    .id_reg1_used_i  (hz.id_reg1_used),
    .id_reg2_used_i  (hz.id_reg2_used),
    .id_sp_used_i    (hz.id_sp_used),
    .id_t_used_i     (hz.id_t_used),
    .id_ih_used_i    (hz.id_ih_used),
    .ieo_wb_addr_i   (hz.ieo_wb_addr),
    .ieo_reg_op_i    (hz.ieo_reg_op),
    .ieo_wb_data_op_i(hz.ieo_wb_data_op),
    .load_use_o      (load_use)
  );
  always_comb begin
    run = !rst && state_q == S_RUN;
    mem = !rst && state_q == S_MEM;
    in_int = !rst && state_q == S_INT;
    last = mem && cnt_q == 3'd1;
    br = hz.ex_branch_taken;
    conflict = hz.emo_ram_op != RAM_OP_NOP && hz.emo_ram_is_inst;
    rc = run && conflict;
    br_run = run && !conflict && br;
    lu = run && !conflict && !br && load_use;
    accept = run && !conflict && !br && !load_use && hz.int_req && hz.ih_int_enable && !blk_q;
    // a multi-cycle access freezes ID/EX and EX/MEM; a same-cycle branch waits in EX
    hold = (rc && LONG) || mem;
    hz.inst_ram_sel = rc || mem ? RAM_SEL_DATA : RAM_SEL_FETCH;
    hz.pc_stall = STALL & ((rc && (LONG || !br)) || mem || lu);
    hz.if_id_stall = STALL & lu;
    hz.id_ex_stall = STALL & hold;
    hz.ex_mem_stall = STALL & hold & !last;
    hz.if_id_flush = FLUSH & (rc || mem || br_run || in_int);
    hz.id_ex_flush = FLUSH & ((rc && !LONG && br) || br_run || lu || in_int);
    hz.mem_wb_flush = FLUSH & hold & !last;
    hz.int_entry = in_int;
    state_d = rc && LONG ? S_MEM : accept ? S_INT : mem && !last ? S_MEM : S_RUN;
    cnt_d = rc && LONG ? CNT_INIT : mem ? cnt_q - 3'd1 : cnt_q;
    // once taken, a request stays masked until IH[15] is seen clear then set again
    blk_d = in_int || (blk_q && hz.ih_int_enable);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q <= 3'd0;
      blk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench; a rule-level model predicts every cycle's controls
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  localparam int RW = 3;
  typedef struct packed {
    logic pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, memwb_f, sel, ent;
  } ctl_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  hazard_ctrl_if hz();
  hazard_ctrl #(.RAM_WAIT(RW)) dut (.clk(clk), .rst(rst), .hz(hz));
  always #5 clk = ~clk;
  ctl_t exp_q[$];
  string tag_q[$];
  int checks = 0;
  int errors = 0;
  int busy = 0;
  bit entry = 0;
  bit blocked = 0;
  ctl_t got, me;
  string mt;
  assign got = {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall,
                hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush, hz.inst_ram_sel, hz.int_entry};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      mt = tag_q.pop_front();
      checks++;
      if (got !== me) begin
        errors++;
        $display("FAIL %s: got=%b expected=%b (pc_s ifid_s idex_s exmem_s ifid_f idex_f memwb_f sel ent)", mt, got, me);
      end
    end
  end

  function automatic bit reads_dest();
    case (hz.ieo_reg_op)
      REG_OP_REG: return (hz.id_reg1_used && hz.id_reg1_addr == hz.ieo_wb_addr)
                      || (hz.id_reg2_used && hz.id_reg2_addr == hz.ieo_wb_addr);
      REG_OP_SP: return hz.id_sp_used;
      REG_OP_T: return hz.id_t_used;
      REG_OP_IH: return hz.id_ih_used;
      default: return 1'b0;
    endcase
  endfunction

  // busy = cycles left with instruction RAM owned by a data access after the first one
  task automatic model(output ctl_t e);
    bit conf, br, lu, was_blk;
    e = '0;
    conf = hz.emo_ram_op != RAM_OP_NOP && hz.emo_ram_is_inst;
    br = hz.ex_branch_taken;
    lu = hz.ieo_wb_data_op == WB_DATA_OP_MEM && reads_dest();
    if (rst) begin
      busy = 0; entry = 0; blocked = 0;
      return;
    end
    if (entry) begin
      e.ent = 1; e.ifid_f = 1; e.idex_f = 1;
      entry = 0; blocked = 1;
      return;
    end
    was_blk = blocked;
    if (!hz.ih_int_enable) blocked = 0;
    if (busy > 0) begin
      e.sel = 1; e.pc_s = 1; e.ifid_f = 1; e.idex_s = 1;
      e.exmem_s = busy > 1; e.memwb_f = busy > 1;
      busy--;
      return;
    end
    if (conf) begin
      e.sel = 1; e.ifid_f = 1;
      if (RW > 1) begin
        e.pc_s = 1; e.idex_s = 1; e.exmem_s = 1; e.memwb_f = 1; busy = RW - 1;
      end else begin
        e.pc_s = !br; e.idex_f = br;
      end
      return;
    end
    if (br) begin
      e.ifid_f = 1; e.idex_f = 1;
      return;
    end
    if (lu) begin
      e.pc_s = 1; e.ifid_s = 1; e.idex_f = 1;
      return;
    end
    if (hz.int_req && hz.ih_int_enable && !was_blk) entry = 1;
  endtask

  task automatic step(input string t);
    ctl_t e;
    model(e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_reg1_addr = '0; hz.id_reg2_addr = '0; hz.ieo_wb_addr = '0;
    hz.id_reg1_used = 0; hz.id_reg2_used = 0; hz.id_sp_used = 0; hz.id_t_used = 0; hz.id_ih_used = 0;
    hz.ieo_reg_op = REG_OP_NONE; hz.ieo_wb_data_op = WB_DATA_OP_ALU;
    hz.emo_ram_op = RAM_OP_NOP; hz.emo_ram_is_inst = 0;
    hz.ex_branch_taken = 0; hz.int_req = 0; hz.ih_int_enable = 0;
  endtask

  task automatic load_r3_addu();
    hz.ieo_wb_addr = 4'd3; hz.ieo_reg_op = REG_OP_REG; hz.ieo_wb_data_op = WB_DATA_OP_MEM;
    hz.id_reg1_addr = 4'd3; hz.id_reg1_used = 1; hz.id_reg2_addr = 4'd1; hz.id_reg2_used = 1;
  endtask

  task automatic sw_to_iram();
    hz.emo_ram_op = RAM_OP_STORE; hz.emo_ram_is_inst = 1;
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    step("reset_a");
    load_r3_addu(); sw_to_iram(); hz.ex_branch_taken = 1;
    step("reset_inputs_active");
    rst = 0; idle();
    step("idle");
    load_r3_addu();
    step("load_use");
    idle();
    step("after_load_use");
    sw_to_iram();
    step("conflict_c0");
    step("conflict_c1");
    step("conflict_c2");
    idle();
    step("conflict_exit");
    load_r3_addu(); hz.ex_branch_taken = 1;
    step("load_use_branch");
    idle(); hz.int_req = 1; hz.ih_int_enable = 1;
    step("int_accept");
    step("int_entry");
    step("int_masked_a");
    step("int_masked_b");
    hz.ih_int_enable = 0;
    step("int_ih_clear");
    hz.ih_int_enable = 1;
    step("int_reaccept");
    step("int_reentry");
    hz.ih_int_enable = 0;
    step("int_disabled_a");
    step("int_disabled_b");
    idle();
    step("idle2");
    sw_to_iram(); hz.int_req = 1; hz.ih_int_enable = 1;
    step("mem_int_c0");
    step("mem_int_c1");
    step("mem_int_c2");
    hz.emo_ram_op = RAM_OP_NOP; hz.emo_ram_is_inst = 0;
    step("mem_int_accept");
    step("mem_int_entry");
    idle();
    step("idle3");
    sw_to_iram(); hz.ih_int_enable = 0;
    step("rst_mid_c0");
    rst = 1;
    #1;
    step("rst_mid_smem");
    step("rst_held");
    rst = 0; idle();
    step("after_rst");
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 99) == 0;
      hz.id_reg1_addr = 4'($urandom_range(0, 3));
      hz.id_reg2_addr = 4'($urandom_range(0, 3));
      hz.ieo_wb_addr = 4'($urandom_range(0, 3));
      hz.id_reg1_used = 1'($urandom_range(0, 1));
      hz.id_reg2_used = 1'($urandom_range(0, 1));
      hz.id_sp_used = 1'($urandom_range(0, 1));
      hz.id_t_used = 1'($urandom_range(0, 1));
      hz.id_ih_used = 1'($urandom_range(0, 1));
      hz.ieo_reg_op = 3'($urandom_range(0, 4));
      hz.ieo_wb_data_op = $urandom_range(0, 1) == 0 ? WB_DATA_OP_MEM : 2'($urandom_range(0, 2));
      hz.emo_ram_op = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 0 ? RAM_OP_LOAD : RAM_OP_STORE) : RAM_OP_NOP;
      hz.emo_ram_is_inst = 1'($urandom_range(0, 1));
      hz.ex_branch_taken = $urandom_range(0, 5) == 0;
      hz.int_req = 1'($urandom_range(0, 1));
      hz.ih_int_enable = $urandom_range(0, 3) != 0;
      step("random");
    end
    rst = 0; idle();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the five-stage MIPS16 core. It sequences stalls, bubbles and flushes so that the forwarding unit only ever sees hazards it can resolve. It handles load-use stalls, the structural conflict when a MEM-stage access targets instruction RAM, taken-branch flushes and interrupt entry. It also drives the select for the shared instruction-RAM port.

## Interface
Parameters:
- `RAM_WAIT`, default 1: number of cycles a data access occupies instruction RAM; legal range 1–7.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_reg1_addr`, `id_reg2_addr` in `REG_ADDR_BUS`: source registers of the instruction in ID.
- `id_reg1_used`, `id_reg2_used`, `id_sp_used`, `id_t_used`, `id_ih_used` in 1 each: the ID instruction reads that operand.
- `ieo_wb_addr` in `REG_ADDR_BUS`: EX-stage destination register.
- `ieo_reg_op` in `REG_OP_BUS`: EX-stage destination register class.
- `ieo_wb_data_op` in `WB_DATA_OP_BUS`: EX-stage write-back source.
- `emo_ram_op` in `RAM_OP_BUS`: MEM-stage access; `RAM_OP_NOP` means no access.
- `emo_ram_is_inst` in 1: the MEM access address lies in instruction RAM.
- `ex_branch_taken` in 1: the EX instruction redirects the PC.
- `int_req` in 1: level interrupt request.
- `ih_int_enable` in 1: forwarded IH[15].
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` out 1 each: hold the register.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: load a bubble.
- `inst_ram_sel` out 1: 0 = fetch, 1 = data.
- `int_entry` out 1: one-cycle pulse; PC loads the vector and EPC is captured.

## Operation
The FSM has three states: `S_RUN`, `S_MEM` and `S_INT`. There is a 3-bit wait counter `cnt`.

All outputs are 0 during reset and, in `S_RUN`, whenever no condition below applies.

Conditions evaluated in `S_RUN`, highest priority first:
1. Structural conflict: `emo_ram_op != NOP && emo_ram_is_inst`.
   - This cycle: `inst_ram_sel=1`, `pc_stall=1`, `if_id_flush=1`.
   - If `RAM_WAIT>1`: also `id_ex_stall=1`, `ex_mem_stall=1`, `mem_wb_flush=1`; load `cnt=RAM_WAIT-1`; go to `S_MEM`.
   - If a branch is taken in the same cycle: `pc_stall=0` and `id_ex_flush=1`.
     - With `RAM_WAIT>1`, the branch is instead held in EX and acted on after `S_MEM` exits.
2. Taken branch (`ex_branch_taken`): `if_id_flush=1`, `id_ex_flush=1`. Load-use detection is suppressed, because the dependent instruction is being flushed.
3. Load-use hazard. Condition: `ieo_wb_data_op==WB_DATA_OP_MEM` and the ID instruction reads the EX destination. The destination matches when either:
   - `REG_OP_REG` with an address match on a used port, or
   - `REG_OP_SP`/`REG_OP_T`/`REG_OP_IH` with the matching `id_*_used`.

   Response: `pc_stall=1`, `if_id_stall=1`, `id_ex_flush=1`, exactly one cycle. The retry is evaluated normally next cycle.
4. Interrupt: `int_req && ih_int_enable` with none of 1–3 active. Go to `S_INT`.

`S_MEM`:
- Outputs: `inst_ram_sel=1`, `pc_stall=1`, `if_id_flush=1`, `id_ex_stall=1`, `ex_mem_stall=1`, `mem_wb_flush=1`.
- `cnt` decrements each cycle. `ex_branch_taken` and `int_req` are ignored.
- When `cnt==1`: `ex_mem_stall=0` and `mem_wb_flush=0`, so the access retires; then go to `S_RUN`.

`S_INT` (one cycle):
- Outputs: `int_entry=1`, `if_id_flush=1`, `id_ex_flush=1`.
- Next state is `S_RUN`. A still-asserted `int_req` is not re-accepted until IH[15] is seen set again via `ih_int_enable`.

Asynchronous reset at any point returns to `S_RUN`, clears `cnt` and drops all outputs immediately.

## Timing
- Every output is combinational from state and inputs; state and `cnt` are registered on the rising edge of `clk`.
- Load-use bubble: exactly 1 cycle.
- Structural conflict: `pc_stall` high for `RAM_WAIT` cycles; EX/MEM held for `RAM_WAIT-1` cycles.
- Interrupt: `int_entry` asserts one cycle after acceptance.
- A stall and a flush on the same register never assert together; flush wins only where stated above.

## Structure
- Shared package: `S_RUN`/`S_MEM`/`S_INT` encodings, `STALL`/`FLUSH` enable constants and `RAM_SEL_FETCH`/`RAM_SEL_DATA`.
- One sub-module, `hazard_detect`: the combinational load-use comparator. The FSM and counter live in `hazard_ctrl`.

## Test plan
- Load R3 in EX, ID `ADDU R3,R1`: one cycle with `pc_stall=1`, `if_id_stall=1`, `id_ex_flush=1`; next cycle all outputs 0.
- `emo_ram_is_inst=1`, SW, `RAM_WAIT=3`: `inst_ram_sel=1` for 3 cycles; `ex_mem_stall=1` for the first 2; return to `S_RUN`.
- Load-use and `ex_branch_taken` together: `if_id_flush=1`, `id_ex_flush=1`, `pc_stall=0`.
- `int_req=1`, `ih_int_enable=1`, idle pipeline: `int_entry` pulses once, one cycle later. With `ih_int_enable=0`: no pulse.
- `int_req` during `S_MEM`: deferred, and `int_entry` pulses one cycle after exit. `rst` raised mid-`S_MEM`: outputs 0 immediately and state `S_RUN`.
